// File: rtl/x_dl_framer_pkg.sv
// Shared definitions for the delay-line framer: FSM state encoding,
// command/header byte constants and frame geometry.
// No ports; imported by x_dl_framer and x_dl_frame_mux.
package x_dl_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [7:0] C_CMD_CAPTURE = 8'h53;  // 'S'
  localparam logic [7:0] C_HDR_DATA    = 8'hA5;
  localparam logic [7:0] C_HDR_TMO     = 8'h5A;

  localparam int         C_FRAME_LEN   = 6;
  localparam logic [2:0] C_LAST_IDX    = 3'(C_FRAME_LEN - 1);

endpackage

// File: rtl/x_dl_frame_mux.sv
// Combinational frame byte selector: picks byte i_idx of the 6-byte frame
// built from a 32-bit word (data frame) or the fixed timeout frame.
// Ports: i_word (captured sample), i_is_data (data vs timeout frame),
//        i_idx (byte index 0..5), o_byte (selected frame byte).
module x_dl_frame_mux
  import x_dl_framer_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic        i_is_data,
  input  logic [2:0]  i_idx,
  output logic [7:0]  o_byte
);

  logic [7:0] w_chk;

  assign w_chk = i_word[31:24] ^ i_word[23:16] ^ i_word[15:8] ^ i_word[7:0];

  // Timeout frame is header followed by all-zero payload and checksum.
  always_comb begin
    o_byte = 8'h00;
    case (i_idx)
      3'd0:    o_byte = i_is_data ? C_HDR_DATA : C_HDR_TMO;
      3'd1:    o_byte = i_is_data ? i_word[31:24] : 8'h00;
      3'd2:    o_byte = i_is_data ? i_word[23:16] : 8'h00;
      3'd3:    o_byte = i_is_data ? i_word[15:8]  : 8'h00;
      3'd4:    o_byte = i_is_data ? i_word[7:0]   : 8'h00;
      3'd5:    o_byte = i_is_data ? w_chk         : 8'h00;
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/x_dl_framer.sv
// Delay-line capture framer, placed between x_uart_rx / x_delay_line and
// x_uart_tx. An 'S' byte arms capture; the next delay-line sample (or a
// timeout after P_TIMEOUT armed cycles) is sent as a 6-byte frame.
// Ports: i_clk/i_rst (async active-high), i_valid/i_data (RX bytes),
//        i_dl_valid/i_dl (samples), o_valid/o_data/i_accept (TX handshake),
//        o_busy (not idle), o_drop_cnt (saturating dropped-'S' count).
module x_dl_framer
  import x_dl_framer_pkg::*;
#(
  parameter int P_TIMEOUT = 65536
)
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_dl_valid,
  input  logic [31:0] i_dl,
  output logic        o_valid,
  input  logic        i_accept,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt
);

  localparam int LP_CW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [LP_CW-1:0] LP_TMO_LAST = LP_CW'(P_TIMEOUT - 1);

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [LP_CW-1:0] r_tmo_cnt;
  logic [31:0]      r_frame;
  logic             r_is_data;
  logic [7:0]       r_drop_cnt;

  logic             w_cmd;
  logic [7:0]       w_byte;

  assign w_cmd = i_valid && (i_data == C_CMD_CAPTURE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_tmo_cnt  <= '0;
      r_frame    <= 32'h0;
      r_is_data  <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else begin
      // A capture command while a capture is already pending is dropped.
      if (w_cmd && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_cmd) begin
            r_state   <= ST_ARM;
            r_tmo_cnt <= '0;
          end
        end
        ST_ARM: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          // A sample on the timeout cycle still wins over the timeout frame.
          if (i_dl_valid) begin
            r_frame   <= i_dl;
            r_is_data <= 1'b1;
            r_idx     <= 3'd0;
            r_state   <= ST_SEND;
          end else if (r_tmo_cnt == LP_TMO_LAST) begin
            r_is_data <= 1'b0;
            r_idx     <= 3'd0;
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_accept) begin
            if (r_idx == C_LAST_IDX) begin
              r_idx   <= 3'd0;
              r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  x_dl_frame_mux u_mux (
    .i_word    (r_frame),
    .i_is_data (r_is_data),
    .i_idx     (r_idx),
    .o_byte    (w_byte)
  );

  // Outputs decode straight from state registers, so reset drops o_valid
  // without waiting for a clock edge. o_data reads zero outside SEND.
  assign o_valid    = (r_state == ST_SEND);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_data     = o_valid ? w_byte : 8'h00;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: doc/x_dl_framer.md
X_DL_FRAMER -- requirements
Module: x_dl_framer

Interface
REQ-001 Parameter: P_TIMEOUT, 65536, number of cycles spent in ARM without a delay-line sample before a timeout frame is sent.
REQ-002 Port: i_clk  input  1  single clock for all state.
REQ-003 Port: i_rst  input  1  reset, asynchronous assert, active-high.
REQ-004 Port: i_valid  input  1  UART RX byte strobe, one cycle per byte.
REQ-005 Port: i_data  input  8  UART RX byte, qualified by i_valid.
REQ-006 Port: i_dl_valid  input  1  delay-line sample strobe.
REQ-007 Port: i_dl  input  32  delay-line thermometer sample, qualified by i_dl_valid.
REQ-008 Port: o_valid  output  1  TX byte request.
REQ-009 Port: i_accept  input  1  UART TX accept.
REQ-010 Port: o_data  output  8  TX byte.
REQ-011 Port: o_busy  output  1  high whenever the state is not IDLE.
REQ-012 Port: o_drop_cnt  output  8  saturating count of dropped capture commands.

Function
REQ-013 FSM states SHALL be IDLE, ARM and SEND, with a 3-bit byte index 0..5 used in SEND.
REQ-014 In IDLE, i_valid=1 with i_data=0x53 ('S') SHALL move the FSM to ARM on the next cycle and clear the timeout counter.
REQ-015 Any other RX byte SHALL be ignored in every state, with no counter change.
REQ-016 An 'S' received outside IDLE SHALL be discarded and SHALL increment o_drop_cnt, which saturates at 255.
REQ-017 In ARM, the first cycle with i_dl_valid=1 SHALL latch i_dl into the frame register and enter SEND with index 0.
REQ-018 An i_dl_valid in the same cycle as the 'S' command SHALL NOT be captured.
REQ-019 The ARM timeout counter SHALL increment every ARM cycle.
REQ-020 At count P_TIMEOUT-1 with i_dl_valid=0, the block SHALL enter SEND with a timeout frame.
REQ-021 If i_dl_valid=1 in the same cycle as the timeout, the data frame SHALL win.
REQ-022 Data frame SHALL be, in order: 0xA5, D[31:24], D[23:16], D[15:8], D[7:0], CHK, where CHK is the XOR of the four data bytes.
REQ-023 Timeout frame SHALL be: 0x5A, 0x00, 0x00, 0x00, 0x00, 0x00.
REQ-024 o_valid SHALL be high in SEND only.
REQ-025 o_valid SHALL assert on the cycle after capture or timeout, without waiting for i_accept.
REQ-026 o_data SHALL equal the byte at the current index and SHALL hold stable while o_valid=1 and i_accept=0.
REQ-027 A byte SHALL transfer on any cycle with o_valid=1 and i_accept=1, after which the index advances by one.
REQ-028 o_valid SHALL remain high between bytes, with no idle cycle inserted.
REQ-029 Acceptance of index 5 SHALL return the FSM to IDLE on the next cycle, with o_valid low in that cycle.
REQ-030 i_accept SHALL be ignored outside SEND.
REQ-031 The frame register SHALL NOT change during SEND; i_dl_valid in SEND or IDLE is ignored.

Reset
REQ-032 On assertion of i_rst, the block SHALL asynchronously set: state IDLE, index 0, timeout counter 0, frame register 0, o_drop_cnt 0, o_valid 0, o_data 0x00, o_busy 0.
REQ-033 Reset mid-frame SHALL abandon the frame, and o_valid SHALL fall without waiting for a clock edge.
REQ-034 After reset release, the first 'S' SHALL behave as in REQ-014.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the byte constants: command 0x53, data header 0xA5, timeout header 0x5A.
REQ-036 The package SHALL also hold the frame length 6.
REQ-037 Sub-module x_dl_frame_mux SHALL be used: a combinational 32-bit word plus index-to-byte selector with CHK generation.
REQ-038 x_dl_framer SHALL sit between x_uart_rx/x_delay_line and x_uart_tx.

Verification
REQ-039 Scenario: 'S', then i_dl=0x0000FFFF after 3 cycles, with i_accept tied high -> bytes A5,00,00,FF,FF,00 on 6 consecutive cycles, then IDLE.
REQ-040 Scenario: 'S', i_dl=0x12345678, i_accept pulsed every 10 cycles -> A5,12,34,56,78,08, each byte held stable until its accept.
REQ-041 Scenario: 'S' with P_TIMEOUT=16 and no i_dl_valid -> o_valid rises 17 cycles after the 'S' cycle, frame 5A,00,00,00,00,00.
REQ-042 Scenario: i_dl_valid coincident with the timeout cycle -> data frame is sent, not the timeout frame.
REQ-043 Scenario: 300 'S' bytes sent while busy -> o_drop_cnt=255, and the frame in progress completes unaffected.
REQ-044 Scenario: i_rst pulsed after byte 2 of a frame is accepted -> o_valid=0 immediately; after the next 'S', a fresh frame starts with A5.
